lcd_char_sequencer: RTL and testbench
=====================================

# lcd_char_sequencer

Command/character sequencer that sits directly upstream of `lcd_controller` and produces the byte stream for an HD44780-style 8-bit character LCD. It runs the power-up wait and init command sequence, then accepts characters from a host over a valid/ready handshake. It tracks the cursor on a 2-row display and inserts DDRAM address commands on line wrap and newline. It honours the inter-command execution delays, so the downstream bus driver only has to strobe `lcd_en`.

## Interface
- `POWER_UP_CYCLES`, 750000: idle cycles after reset release before the first init command (15 ms at 50 MHz).
- `CMD_WAIT_CYCLES`, 2000: wait after every accepted byte except clear/home (40 µs).
- `CLEAR_WAIT_CYCLES`, 82000: wait after 0x01 (clear) or 0x02 (home) (1.64 ms).
- `COLS`, 16: characters per row; legal range 2..64.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `char_valid` in 1: host offers `char_data`.
- `char_data` in 8: ASCII byte; 0x0A means newline.
- `char_ready` out 1: sequencer accepts a char this cycle.
- `clear_req` in 1: single-cycle pulse requesting a display clear.
- `out_valid` out 1: byte offered to `lcd_controller`.
- `out_ready` in 1: downstream accepts the byte.
- `out_rs` out 1: 0 = command, 1 = data.
- `out_data` out 8: byte to write.
- `init_done` out 1: init sequence complete; sticky until reset.
- `busy` out 1: high in every state except IDLE.
- `cursor_row` out 1: current row.
- `cursor_col` out 6: current column, 0..COLS-1.

## Operation
- States: PWR_WAIT → INIT_SEND → INIT_WAIT (looped 4×) → IDLE ⇄ {SEND → WAIT → [ADDR_SEND → ADDR_WAIT]} → IDLE.
- Init bytes, in order, all with rs=0: 0x38 (8-bit, 2 lines), 0x0C (display on), 0x06 (entry increment), 0x01 (clear). `init_done` rises on the cycle INIT_WAIT of 0x01 expires.
- IDLE, `init_done`=1: `char_ready`=1 unless a clear is pending.
- Pending clear:
  - `clear_req` sets a sticky pending flag.
  - In IDLE, a pending clear has priority over `char_valid`. `char_ready` is 0 that cycle.
  - The sequencer sends 0x01 and resets the cursor to (0,0).
  - A `clear_req` arriving before `init_done` is discarded, because init already clears.
- Printable char: sent with rs=1; col increments after the downstream accept.
  - If col was COLS-1: col←0, row toggles, then ADDR_SEND issues 0x80|(row?0x40:0x00), rs=0.
- Newline (0x0A): no data byte is sent. Col←0, row toggles, and ADDR_SEND issues the address command for the new row.
- Output handshake:
  - A transfer occurs when `out_valid`&&`out_ready`.
  - While `out_valid`=1 and `out_ready`=0, `out_valid`, `out_rs` and `out_data` are held stable.
  - `out_valid` never drops without a transfer.
- Wait counters load on the transfer cycle. The sequencer leaves WAIT after exactly N cycles, where N is CLEAR_WAIT_CYCLES for 0x01/0x02 and CMD_WAIT_CYCLES otherwise.
- Reset asserted mid-operation: all state is aborted immediately (async). After release, the sequencer restarts from PWR_WAIT and re-runs full init.

## Timing
- Reset values: `char_ready`=0, `out_valid`=0, `out_rs`=0, `out_data`=0x00, `init_done`=0, `busy`=1, `cursor_row`=0, `cursor_col`=0. The internal state is PWR_WAIT.
- First `out_valid` is asserted POWER_UP_CYCLES cycles after the first rising edge with `rst_n`=1.
- Char accepted at edge N: `out_valid` is high from N+1.
- Transfer at edge M: the next `out_valid` is no earlier than M+1+wait. `char_ready` is high again at M+1+wait when there is no address follow-up.
- Counter width is $clog2(max(POWER_UP_CYCLES, CLEAR_WAIT_CYCLES)+1). Counters do not wrap.
- `out_ready` low for K cycles delays the transfer by K. The wait does not start until the transfer.

## Structure
- `lcd_pkg`:
  - Command constants: CMD_FUNC_SET=0x38, CMD_DISP_ON=0x0C, CMD_ENTRY=0x06, CMD_CLEAR=0x01, CMD_HOME=0x02, CMD_DDRAM=0x80, ROW1_BASE=0x40, CHAR_NL=0x0A.
  - State enum.
- Sub-module `lcd_delay_timer`: load value plus `load` strobe in, `done` out. It is shared by the power-up wait and all command waits.

## Test plan
All scenarios use POWER_UP_CYCLES=20, CMD_WAIT_CYCLES=4, CLEAR_WAIT_CYCLES=10, COLS=4; `out_ready`=1 unless stated.
- Release reset:
  - First `out_valid` 20 cycles later, then bytes 0x38, 0x0C, 0x06, 0x01, all rs=0, each 5 cycles apart.
  - `init_done`=1 11 cycles after the 0x01 transfer.
- After init, char 0x41:
  - 0x41 with rs=1 on `out_*` the next cycle.
  - `cursor_col`=1.
  - `char_ready` back to 1 five cycles after the transfer.
- Chars "ABCD": after 'D', 0xC0 rs=0 with cursor (1,0). Chars "EFGH": after 'H', 0x80 with cursor (0,0).
- Newline at (0,2): only 0xC0 rs=0 is emitted, no data byte; cursor goes to (1,0).
- `clear_req` and `char_valid`=0x5A in the same IDLE cycle:
  - `char_ready`=0; 0x01 is emitted first; cursor goes to (0,0).
  - 11 cycles later the char is accepted and 0x5A is emitted.
- Stall and reset:
  - Hold `out_ready`=0 for 7 cycles during a data byte: `out_valid`/`out_data` stay stable and the transfer happens on the 8th cycle.
  - Then pull `rst_n` low mid-WAIT: all outputs reach reset values without a clock edge, and init re-runs after release.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, FSM state type and byte helpers for the HD44780 character sequencer.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_DDRAM    = 8'h80;
    localparam logic [7:0] ROW1_BASE    = 8'h40;
    localparam logic [7:0] CHAR_NL      = 8'h0A;

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_INIT_SEND,
        S_INIT_WAIT,
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_ADDR_SEND,
        S_ADDR_WAIT
    } state_t;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_ENTRY;
            default: return CMD_CLEAR;
        endcase
    endfunction

    function automatic logic [7:0] ddram_addr(input logic row);
        return CMD_DDRAM | (row ? ROW1_BASE : 8'h00);
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Down-counter shared by the power-up wait and every post-command execution wait.
module lcd_delay_timer #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    // Saturates at zero so a finished wait stays finished until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/lcd_char_sequencer.sv
// Power-up/init sequencing, host character intake and cursor tracking for a 2-row HD44780 LCD.
module lcd_char_sequencer
    import lcd_pkg::*;
#(
    parameter int POWER_UP_CYCLES   = 750000,
    parameter int CMD_WAIT_CYCLES   = 2000,
    parameter int CLEAR_WAIT_CYCLES = 82000,
    parameter int COLS              = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    input  logic       clear_req,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_rs,
    output logic [7:0] out_data,
    output logic       init_done,
    output logic       busy,
    output logic       cursor_row,
    output logic [5:0] cursor_col
);

    localparam int MAX_WAIT = (POWER_UP_CYCLES > CLEAR_WAIT_CYCLES) ? POWER_UP_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int TW       = $clog2(MAX_WAIT + 1);

    // Timer is loaded with N-1 so that the wait state is left on exactly the Nth cycle.
    localparam logic [TW-1:0] PWR_LOAD   = TW'(POWER_UP_CYCLES - 1);
    localparam logic [TW-1:0] CMD_LOAD   = TW'(CMD_WAIT_CYCLES - 1);
    localparam logic [TW-1:0] CLEAR_LOAD = TW'(CLEAR_WAIT_CYCLES - 1);
    localparam logic [5:0]    LAST_COL   = 6'(COLS - 1);

    state_t        state;
    logic [1:0]    init_idx;
    logic [1:0]    next_idx;
    logic          clr_pend;
    logic          addr_pend;
    logic          xfer;
    logic          long_cmd;
    logic          tmr_done;
    logic [TW-1:0] tmr_val;

    assign xfer     = out_valid && out_ready;
    assign long_cmd = !out_rs && ((out_data == CMD_CLEAR) || (out_data == CMD_HOME));
    assign tmr_val  = long_cmd ? CLEAR_LOAD : CMD_LOAD;
    assign next_idx = init_idx + 2'd1;

    lcd_delay_timer #(
        .W       (TW),
        .RST_VAL (PWR_LOAD)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (xfer),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // A clear arriving in the same cycle as a character must win, so this looks at clear_req directly.
    assign char_ready = (state == S_IDLE) && init_done && !clr_pend && !clear_req;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_PWR_WAIT;
            init_idx   <= 2'd0;
            init_done  <= 1'b0;
            clr_pend   <= 1'b0;
            addr_pend  <= 1'b0;
            out_valid  <= 1'b0;
            out_rs     <= 1'b0;
            out_data   <= 8'h00;
            cursor_row <= 1'b0;
            cursor_col <= 6'd0;
        end else begin
            if (clear_req && init_done) begin
                clr_pend <= 1'b1;
            end
            case (state)
                S_PWR_WAIT: begin
                    if (tmr_done) begin
                        state     <= S_INIT_SEND;
                        out_valid <= 1'b1;
                        out_rs    <= 1'b0;
                        out_data  <= init_byte(init_idx);
                    end
                end
                S_INIT_SEND: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        state     <= S_INIT_WAIT;
                    end
                end
                S_INIT_WAIT: begin
                    if (tmr_done) begin
                        if (init_idx == 2'd3) begin
                            init_done <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            init_idx  <= next_idx;
                            out_valid <= 1'b1;
                            out_rs    <= 1'b0;
                            out_data  <= init_byte(next_idx);
                            state     <= S_INIT_SEND;
                        end
                    end
                end
                S_IDLE: begin
                    if (clr_pend || clear_req) begin
                        clr_pend  <= 1'b0;
                        out_valid <= 1'b1;
                        out_rs    <= 1'b0;
                        out_data  <= CMD_CLEAR;
                        state     <= S_SEND;
                    end else if (char_valid) begin
                        out_valid <= 1'b1;
                        if (char_data == CHAR_NL) begin
                            cursor_col <= 6'd0;
                            cursor_row <= !cursor_row;
                            out_rs     <= 1'b0;
                            out_data   <= ddram_addr(!cursor_row);
                            state      <= S_ADDR_SEND;
                        end else begin
                            out_rs   <= 1'b1;
                            out_data <= char_data;
                            state    <= S_SEND;
                        end
                    end
                end
                S_SEND: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        state     <= S_WAIT;
                        if (out_rs) begin
                            if (cursor_col == LAST_COL) begin
                                cursor_col <= 6'd0;
                                cursor_row <= !cursor_row;
                                addr_pend  <= 1'b1;
                            end else begin
                                cursor_col <= cursor_col + 6'd1;
                            end
                        end else if (out_data == CMD_CLEAR) begin
                            cursor_row <= 1'b0;
                            cursor_col <= 6'd0;
                        end
                    end
                end
                S_WAIT: begin
                    if (tmr_done) begin
                        if (addr_pend) begin
                            addr_pend <= 1'b0;
                            out_valid <= 1'b1;
                            out_rs    <= 1'b0;
                            out_data  <= ddram_addr(cursor_row);
                            state     <= S_ADDR_SEND;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_ADDR_SEND: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        state     <= S_ADDR_WAIT;
                    end
                end
                S_ADDR_WAIT: begin
                    if (tmr_done) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_PWR_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_char_sequencer.sv
// Scoreboard bench: stimulus pushes expected LCD bytes, a negedge monitor pops and compares on each transfer.
module tb_lcd_char_sequencer;

    localparam int P    = 20;
    localparam int CW   = 4;
    localparam int CLW  = 10;
    localparam int COLS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       char_valid = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       clear_req = 1'b0;
    logic       out_ready = 1'b1;
    logic       char_ready;
    logic       out_valid;
    logic       out_rs;
    logic [7:0] out_data;
    logic       init_done;
    logic       busy;
    logic       cursor_row;
    logic [5:0] cursor_col;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         last_xfer = 0;
    int         n_xfer = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_e;

    lcd_char_sequencer #(
        .POWER_UP_CYCLES   (P),
        .CMD_WAIT_CYCLES   (CW),
        .CLEAR_WAIT_CYCLES (CLW),
        .COLS              (COLS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rs     (out_rs),
        .out_data   (out_data),
        .init_done  (init_done),
        .busy       (busy),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted byte must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_byte: got rs=%0d data=%02h, expected no byte", out_rs, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_rs, out_data} !== mon_e) begin
                    failures++;
                    $display("FAIL out_byte: got rs=%0d data=%02h, expected rs=%0d data=%02h",
                             out_rs, out_data, mon_e[8], mon_e[7:0]);
                end
            end
            last_xfer <= cyc;
            n_xfer    <= n_xfer + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic wait_valid(input int maxc, output int at);
        int k = 0;
        do begin @(negedge clk); #1; k++; end while (!out_valid && k < maxc);
        at = cyc;
        if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_ready(input int maxc, output int at);
        int k = 0;
        do begin @(negedge clk); #1; k++; end while (!char_ready && k < maxc);
        at = cyc;
        if (!char_ready) check("char_ready_timeout", 32'(char_ready), 32'd1);
    endtask

    task automatic wait_init(input int maxc, output int at);
        int k = 0;
        do begin @(negedge clk); #1; k++; end while (!init_done && k < maxc);
        at = cyc;
        if (!init_done) check("init_done_timeout", 32'(init_done), 32'd1);
    endtask

    task automatic wait_nx(input int target, input int maxc, output int at);
        int k = 0;
        do begin @(negedge clk); #1; k++; end while (n_xfer < target && k < maxc);
        at = last_xfer;
        if (n_xfer < target) check("xfer_timeout", 32'(n_xfer), 32'(target));
    endtask

    task automatic send_char(input logic [7:0] c, output int acc);
        acc = -1;
        @(posedge clk); #1;
        char_valid = 1'b1;
        char_data  = c;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (char_ready) begin
                acc = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        char_valid = 1'b0;
        if (acc < 0) check("char_accept_timeout", 32'(char_ready), 32'd1);
    endtask

    task automatic check_cursor(input string name, input logic row, input logic [5:0] col);
        check({name, "_row"}, 32'(cursor_row), 32'(row));
        check({name, "_col"}, 32'(cursor_col), 32'(col));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_char_ready"}, 32'(char_ready), 32'd0);
        check({tag, "_out_valid"},  32'(out_valid),  32'd0);
        check({tag, "_out_rs"},     32'(out_rs),     32'd0);
        check({tag, "_out_data"},   32'(out_data),   32'd0);
        check({tag, "_init_done"},  32'(init_done),  32'd0);
        check({tag, "_busy"},       32'(busy),       32'd1);
        check_cursor(tag, 1'b0, 6'd0);
    endtask

    task automatic run_init();
        int rel;
        int at;
        int prev;
        int base;
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
        base = n_xfer;
        @(posedge clk); #2;
        rst_n = 1'b1;
        rel = cyc;
        wait_valid(100, at);
        check("power_up_cycles", 32'(at - rel), 32'(P));
        prev = 0;
        for (int i = 1; i <= 4; i++) begin
            wait_nx(base + i, 50, at);
            if (i > 1) check("init_gap", 32'(at - prev), 32'(CW + 1));
            prev = at;
        end
        wait_init(50, at);
        check("init_done_delay", 32'(at - prev), 32'(CLW + 1));
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_char_ready", 32'(char_ready), 32'd1);
    endtask

    task automatic send_str(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
        logic [7:0] s [4];
        int acc;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b1, s[i]});
            send_char(s[i], acc);
        end
    endtask

    initial begin
        int at;
        int t;
        int acc;
        int nx;

        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("reset");

        run_init();

        // Single printable character.
        nx = n_xfer;
        exp_q.push_back({1'b1, 8'h41});
        send_char(8'h41, acc);
        check("valid_after_accept", 32'(out_valid), 32'd1);
        check("data_after_accept", 32'({out_rs, out_data}), 32'h141);
        wait_nx(nx + 1, 20, t);
        @(posedge clk); #1;
        check_cursor("after_A", 1'b0, 6'd1);
        wait_ready(50, at);
        check("ready_after_char", 32'(at - t), 32'(CW + 1));

        // Clear and character offered together: clear goes first.
        @(posedge clk); #1;
        clear_req  = 1'b1;
        char_valid = 1'b1;
        char_data  = 8'h5A;
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b1, 8'h5A});
        @(negedge clk);
        check("ready_during_clear", 32'(char_ready), 32'd0);
        @(posedge clk); #1;
        clear_req = 1'b0;
        wait_ready(60, at);
        check("clear_to_accept", 32'(at - last_xfer), 32'(CLW + 1));
        check_cursor("after_clear", 1'b0, 6'd0);
        @(posedge clk); #1;
        char_valid = 1'b0;
        wait_ready(50, at);
        check_cursor("after_Z", 1'b0, 6'd1);

        // Newline at column 2: only an address command is emitted.
        exp_q.push_back({1'b1, 8'h42});
        send_char(8'h42, acc);
        wait_ready(50, at);
        check_cursor("before_nl", 1'b0, 6'd2);
        nx = n_xfer;
        exp_q.push_back({1'b0, 8'hC0});
        send_char(8'h0A, acc);
        wait_ready(50, at);
        check("nl_byte_count", 32'(n_xfer - nx), 32'd1);
        check_cursor("after_nl", 1'b1, 6'd0);
        exp_q.push_back({1'b0, 8'h80});
        send_char(8'h0A, acc);
        wait_ready(50, at);
        check_cursor("after_nl2", 1'b0, 6'd0);

        // Line wraps in both directions.
        send_str(8'h41, 8'h42, 8'h43, 8'h44);
        exp_q.push_back({1'b0, 8'hC0});
        wait_ready(50, at);
        check_cursor("after_ABCD", 1'b1, 6'd0);
        check("queue_after_ABCD", 32'(exp_q.size()), 32'd0);
        send_str(8'h45, 8'h46, 8'h47, 8'h48);
        exp_q.push_back({1'b0, 8'h80});
        wait_ready(50, at);
        check_cursor("after_EFGH", 1'b0, 6'd0);
        check("queue_after_EFGH", 32'(exp_q.size()), 32'd0);

        // Downstream stall for 7 cycles on a data byte.
        @(posedge clk); #1;
        out_ready = 1'b0;
        nx = n_xfer;
        exp_q.push_back({1'b1, 8'h53});
        send_char(8'h53, acc);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_byte", 32'({out_rs, out_data}), 32'h153);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk); #1;
        check("stall_xfer_8th", 32'(n_xfer - nx), 32'd1);
        @(posedge clk); #1;
        check_cursor("after_stall", 1'b0, 6'd1);

        // Asynchronous reset in the middle of the post-byte wait.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        check("queue_at_reset", 32'(exp_q.size()), 32'd0);
        run_init();

        repeat (3) @(negedge clk);
        check("queue_final", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
